// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// A grant registers the winner's select/operands toward the ALU, acks the
// winner for one cycle, then captures the ALU result with the owner's ID.
module alu_rr_arbiter #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [2:0]       sel0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [2:0]       sel1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             ack0,
  output logic             ack1,
  output logic [2:0]       alu_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_q,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             result_id,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic last_grant;
  logic grant_id;
  logic grant_any;
  logic winner;

  // Round-robin pick: on a tie the requester that did not win last time goes
  always_comb begin
    grant_any = req0 | req1;
    winner    = req1 & (~req0 | ~last_grant);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic: requests are only considered in IDLE
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_any) state_next = EXEC;
      EXEC:    state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Registered datapath: ALU operand issue, grant bookkeeping, result capture
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_sel    <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      result     <= '0;
      result_id  <= 1'b0;
      grant_id   <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      if (state == IDLE && grant_any) begin
        alu_sel    <= winner ? sel1 : sel0;
        alu_a      <= winner ? a1 : a0;
        alu_b      <= winner ? b1 : b0;
        last_grant <= winner;
        grant_id   <= winner;
      end
      if (state == EXEC) begin
        result    <= alu_q;
        result_id <= grant_id;
      end
    end
  end

  // Outputs decoded from registered state, so each pulse lasts exactly one cycle
  always_comb begin
    ack0         = (state == EXEC) & ~grant_id;
    ack1         = (state == EXEC) &  grant_id;
    result_valid = (state == DONE);
    busy         = (state != IDLE);
  end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter with a behavioural ALU in the feedback path.
module tb_alu_rr_arbiter;

  localparam int WIDTH = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0, req1;
  logic [2:0]       sel0, sel1;
  logic [WIDTH-1:0] a0, b0, a1, b1;
  logic             ack0, ack1;
  logic [2:0]       alu_sel;
  logic [WIDTH-1:0] alu_a, alu_b, alu_q;
  logic [WIDTH-1:0] result;
  logic             result_valid, result_id, busy;

  int total = 0;
  int bad   = 0;

  alu_rr_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .sel0(sel0), .a0(a0), .b0(b0),
    .req1(req1), .sel1(sel1), .a1(a1), .b1(b1),
    .ack0(ack0), .ack1(ack1),
    .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_q(alu_q),
    .result(result), .result_valid(result_valid), .result_id(result_id),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Shared ALU: 0 pass A, 1 add, 2 sub, 3 and, 4 or, 5 xor, 6 not A, 7 inc A
  always_comb begin
    alu_q = '0;
    case (alu_sel)
      3'd0: alu_q = alu_a;
      3'd1: alu_q = alu_a + alu_b;
      3'd2: alu_q = alu_a - alu_b;
      3'd3: alu_q = alu_a & alu_b;
      3'd4: alu_q = alu_a | alu_b;
      3'd5: alu_q = alu_a ^ alu_b;
      3'd6: alu_q = ~alu_a;
      3'd7: alu_q = alu_a + 3'd1;
      default: alu_q = '0;
    endcase
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Sampled at negedge: ack0, ack1, busy, result_valid
  task automatic chk_ctl(input string tag, input logic e_ack0, input logic e_ack1,
                         input logic e_busy, input logic e_rv);
    chk({tag, ".ack0"}, {7'd0, ack0}, {7'd0, e_ack0});
    chk({tag, ".ack1"}, {7'd0, ack1}, {7'd0, e_ack1});
    chk({tag, ".busy"}, {7'd0, busy}, {7'd0, e_busy});
    chk({tag, ".rv"},   {7'd0, result_valid}, {7'd0, e_rv});
  endtask

  task automatic chk_res(input string tag, input logic [2:0] e_res, input logic e_id);
    chk({tag, ".result"}, {5'd0, result}, {5'd0, e_res});
    chk({tag, ".id"}, {7'd0, result_id}, {7'd0, e_id});
  endtask

  initial begin
    reset = 1'b1;
    req0 = 0; sel0 = '0; a0 = '0; b0 = '0;
    req1 = 0; sel1 = '0; a1 = '0; b1 = '0;
    repeat (3) @(negedge clk);

    // Reset state
    chk_ctl("rst", 0, 0, 0, 0);
    chk_res("rst", 3'd0, 0);
    chk("rst.alu_sel", {5'd0, alu_sel}, 8'd0);
    chk("rst.alu_a", {5'd0, alu_a}, 8'd0);
    chk("rst.alu_b", {5'd0, alu_b}, 8'd0);
    reset = 0;

    // Single add: 5 + 2 = 7 for requester 0
    @(negedge clk);
    req0 = 1; sel0 = 3'd1; a0 = 3'd5; b0 = 3'd2;
    @(negedge clk);
    chk_ctl("add.n1", 1, 0, 1, 0);
    chk("add.alu_sel", {5'd0, alu_sel}, 8'd1);
    chk("add.alu_a", {5'd0, alu_a}, 8'd5);
    chk("add.alu_b", {5'd0, alu_b}, 8'd2);
    req0 = 0;
    @(negedge clk);
    chk_ctl("add.n2", 0, 0, 1, 1);
    chk_res("add.n2", 3'd7, 0);
    @(negedge clk);
    chk_ctl("add.n3", 0, 0, 0, 0);
    chk_res("add.hold", 3'd7, 0);
    chk("add.alu_a_hold", {5'd0, alu_a}, 8'd5);

    // Wrap-around: 7 + 1 = 0 for requester 1
    req1 = 1; sel1 = 3'd1; a1 = 3'd7; b1 = 3'd1;
    @(negedge clk);
    chk_ctl("wrap.n1", 0, 1, 1, 0);
    req1 = 0;
    @(negedge clk);
    chk_ctl("wrap.n2", 0, 0, 1, 1);
    chk_res("wrap.n2", 3'd0, 1);
    @(negedge clk);

    // Tie after reset: requester 0 first (5-2=3), then requester 1 (3+1=4)
    reset = 1;
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    req0 = 1; sel0 = 3'd2; a0 = 3'd5; b0 = 3'd2;
    req1 = 1; sel1 = 3'd7; a1 = 3'd3; b1 = 3'd0;
    @(negedge clk);
    chk_ctl("tie.n1", 1, 0, 1, 0);
    req0 = 0;
    @(negedge clk);
    chk_ctl("tie.n2", 0, 0, 1, 1);
    chk_res("tie.n2", 3'd3, 0);
    @(negedge clk);
    chk_ctl("tie.n3", 0, 0, 0, 0);
    @(negedge clk);
    chk_ctl("tie.n4", 0, 1, 1, 0);
    chk("tie.alu_sel", {5'd0, alu_sel}, 8'd7);
    req1 = 0;
    @(negedge clk);
    chk_ctl("tie.n5", 0, 0, 1, 1);
    chk_res("tie.n5", 3'd4, 1);
    @(negedge clk);

    // Sustained contention: last winner was 1, so grants go 0,1,0,1
    req0 = 1; sel0 = 3'd1; a0 = 3'd1; b0 = 3'd1;  // 2
    req1 = 1; sel1 = 3'd5; a1 = 3'd6; b1 = 3'd3;  // 5
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk_ctl($sformatf("cont%0d.ack", k), (k % 2) == 0, (k % 2) == 1, 1, 0);
      @(negedge clk);
      chk_ctl($sformatf("cont%0d.rv", k), 0, 0, 1, 1);
      chk_res($sformatf("cont%0d", k), ((k % 2) == 0) ? 3'd2 : 3'd5, (k % 2) == 1);
      @(negedge clk);
      chk_ctl($sformatf("cont%0d.idle", k), 0, 0, 0, 0);
      if (k == 3) begin
        req0 = 0; req1 = 0;
      end
    end
    @(negedge clk);

    // Ignore during busy: req1 rises in EXEC of a requester-0 op (6&3=2, then 4|1=5)
    req0 = 1; sel0 = 3'd3; a0 = 3'd6; b0 = 3'd3;
    @(negedge clk);
    chk_ctl("busy.n1", 1, 0, 1, 0);
    req0 = 0;
    req1 = 1; sel1 = 3'd4; a1 = 3'd4; b1 = 3'd1;
    @(negedge clk);
    chk_ctl("busy.n2", 0, 0, 1, 1);
    chk_res("busy.n2", 3'd2, 0);
    @(negedge clk);
    chk_ctl("busy.n3", 0, 0, 0, 0);
    @(negedge clk);
    chk_ctl("busy.n4", 0, 1, 1, 0);
    req1 = 0;
    @(negedge clk);
    chk_ctl("busy.n5", 0, 0, 1, 1);
    chk_res("busy.n5", 3'd5, 1);
    @(negedge clk);

    // Reset mid-op: requester 0 (sel 6) aborted in EXEC; req1 high during reset is ignored
    req0 = 1; sel0 = 3'd6; a0 = 3'd6; b0 = 3'd3;
    @(negedge clk);
    chk_ctl("abort.n1", 1, 0, 1, 0);
    req0 = 0;
    reset = 1;
    req1 = 1; sel1 = 3'd1; a1 = 3'd2; b1 = 3'd2;
    @(negedge clk);
    chk_ctl("abort.n2", 0, 0, 0, 0);
    chk_res("abort.n2", 3'd0, 0);
    chk("abort.alu_sel", {5'd0, alu_sel}, 8'd0);
    chk("abort.alu_a", {5'd0, alu_a}, 8'd0);
    reset = 0;
    req1 = 0;
    @(negedge clk);
    chk_ctl("abort.n3", 0, 0, 0, 0);

    // Pointer was restored by reset: requester 0 wins this tie
    req0 = 1; sel0 = 3'd0; a0 = 3'd3; b0 = 3'd0;
    req1 = 1;
    @(negedge clk);
    chk_ctl("post.n1", 1, 0, 1, 0);
    req0 = 0; req1 = 0;
    @(negedge clk);
    chk_ctl("post.n2", 0, 0, 1, 1);
    chk_res("post.n2", 3'd3, 0);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
- Shares one combinational 3-bit ALU between two requesters using a round-robin policy.
- Each requester presents a select code and two operands, and receives an ack when its operation is issued.
- The result is registered, returned with a valid pulse, and tagged with the requester ID.
- Sits between the datapath's operation sources and the shared ALU. The ALU's select/A/B inputs are driven from this block's registered outputs, and the ALU's Q output feeds back into alu_q.

Parameters:
- WIDTH, 3, operand/result width; must match the ALU width.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- req0  input  1  requester 0 operation request; held until ack0
- sel0  input  3  requester 0 ALU select code
- a0  input  WIDTH  requester 0 operand A
- b0  input  WIDTH  requester 0 operand B
- req1  input  1  requester 1 operation request; held until ack1
- sel1  input  3  requester 1 ALU select code
- a1  input  WIDTH  requester 1 operand A
- b1  input  WIDTH  requester 1 operand B
- ack0  output  1  one-cycle pulse: requester 0 operation issued
- ack1  output  1  one-cycle pulse: requester 1 operation issued
- alu_sel  output  3  registered select code to the shared ALU
- alu_a  output  WIDTH  registered operand A to the ALU
- alu_b  output  WIDTH  registered operand B to the ALU
- alu_q  input  WIDTH  combinational ALU result
- result  output  WIDTH  registered ALU result
- result_valid  output  1  one-cycle pulse: result is valid
- result_id  output  1  requester that owns result (0/1)
- busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset (synchronous, active-high): clears state and all outputs.
  - state=IDLE.
  - ack0=ack1=0, result_valid=0, busy=0.
  - result=0, result_id=0.
  - alu_sel=0, alu_a=0, alu_b=0.
  - last_grant=1, so requester 0 wins the first tie.
- FSM has three states: IDLE, EXEC, DONE.
- IDLE:
  - Requests are sampled only in this state.
  - If no request, stay in IDLE.
  - If exactly one request, grant it.
  - If both request, grant the requester that is not last_grant.
  - On a grant (edge ending cycle N):
    - Load alu_sel/alu_a/alu_b from the winner's inputs.
    - Set last_grant := winner and latch grant id.
    - Assert the winner's ack for cycle N+1.
    - Move to EXEC.
- EXEC (cycle N+1):
  - The ALU inputs are stable and the winner's ack is high, for this cycle only.
  - At the edge ending N+1: result := alu_q, result_id := grant id, result_valid := 1.
  - Move to DONE.
- DONE (cycle N+2):
  - result_valid=1 for this cycle only.
  - At the edge ending N+2, return to IDLE.
- Timing and throughput:
  - Latency from the request sample to result_valid is 2 cycles.
  - Maximum throughput is 1 operation per 3 cycles.
- Signal persistence:
  - alu_sel/alu_a/alu_b hold their last issued values until the next grant.
  - result and result_id hold their values after result_valid drops.
- Handshake:
  - A requester must hold req and its operands stable until it sees ack.
  - A requester drops req no later than the cycle after ack (N+2).
  - A req still high at the next IDLE sample counts as a new request.
- Arithmetic: none in this block. The ALU wraps modulo 2^WIDTH, and result carries alu_q unchanged.
- Boundary conditions:
  - A request arriving during EXEC/DONE is ignored until IDLE.
  - A loser of a tie keeps req high and is granted at the next IDLE.
  - The pointer alternates under continuous contention, so no starvation.
  - A single requester is granted every IDLE regardless of last_grant.
  - Reset in EXEC or DONE aborts the operation: no result_valid, no further ack, state returns to IDLE the next cycle.
  - reset and req both high in the same cycle: reset wins.

Test Plan:
- Single add: req0=1, sel0=1, a0=5, b0=2 in IDLE → ack0 at N+1; result=7, result_id=0, result_valid=1 at N+2; busy high for N+1..N+2.
- Wrap-around: req1=1, sel1=1, a1=7, b1=1 → ack1 at N+1; result=0, result_id=1 at N+2.
- Tie after reset: req0 (sel=2, a=5, b=2) and req1 (sel=7, a=3) both held → requester 0 first (result=3, id=0); requester 1 granted at the next IDLE (result=4, id=1); no overlap of acks.
- Sustained contention: both req held for 4 operations → grants alternate 0,1,0,1; one result_valid every 3 cycles.
- Ignore during busy: req1 rises in EXEC of a requester-0 op → no ack1 until the following IDLE; then granted normally.
- Reset mid-op: reset in EXEC of req0 (sel=6, a=6, b=3) → next cycle all outputs 0, state IDLE, no result_valid; requester 0 wins the following tie.
